// File: rtl/i2c_slave.sv
// I2C target (responder). Oversamples SCL/SDA on clk, detects START/STOP,
// matches a 7-bit address, delivers write bytes to the core and fetches read
// bytes through a tx_req/tx_data handshake. SDA is open-drain only.
//
// Ports:
//   clk       system clock, at least 8x SCL
//   res       synchronous active-low reset
//   scl_in    raw SCL pin level (asynchronous)
//   sda_in    raw SDA pin level (asynchronous)
//   sda_oe    1 = pull SDA low, 0 = release
//   rx_data   last received write byte
//   rx_valid  one-cycle strobe for rx_data
//   rx_first  with rx_valid, marks the first data byte after the address
//   tx_req    one-cycle request for the next read byte
//   tx_data   read byte, sampled at the SCL fall after tx_req
//   busy      high from address match until the next STOP or START
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h3e
) (
  input  logic       clk,
  input  logic       res,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_first,
  output logic       tx_req,
  input  logic [7:0] tx_data,
  output logic       busy
);

  typedef enum logic [2:0] {
    StIdle, StAddr, StAddrAck, StWrite, StWriteAck, StRead, StMack, StIgnore
  } state_e;

  // [1:0] two-flop synchronizer, [2] history flop
  logic [2:0] scl_q, sda_q;
  logic       scl_s, sda_s, scl_rise, scl_fall, start, stop;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] sr_q, sr_d;
  logic       rw_q, rw_d;
  logic       ack_q, ack_d;
  logic       first_q, first_d;
  logic       sda_oe_q, sda_oe_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       rx_first_q, rx_first_d;
  logic       tx_req_q, tx_req_d;
  logic       busy_q, busy_d;

  assign scl_s    = scl_q[1];
  assign sda_s    = sda_q[1];
  assign scl_rise = scl_s & ~scl_q[2];
  assign scl_fall = ~scl_s & scl_q[2];
  assign start    = scl_s & ~sda_s & sda_q[2];
  assign stop     = scl_s & sda_s & ~sda_q[2];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sr_d       = sr_q;
    rw_d       = rw_q;
    ack_d      = ack_q;
    first_d    = first_q;
    sda_oe_d   = sda_oe_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_first_d = 1'b0;
    tx_req_d   = 1'b0;
    busy_d     = busy_q;

    if (start) begin
      state_d  = StAddr;
      cnt_d    = 4'd0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (stop) begin
      state_d  = StIdle;
      cnt_d    = 4'd0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        StIdle: ;
        StAddr: begin
          if (scl_rise) begin
            sr_d  = {sr_q[6:0], sda_s};
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              rw_d = sda_s;
              if (sr_q[6:0] != SLAVE_ADDR) state_d = StIgnore;
            end
          end else if (scl_fall && cnt_q == 4'd8) begin
            // Only a matching address survives to the 8th fall
            state_d  = StAddrAck;
            sda_oe_d = 1'b1;
            busy_d   = 1'b1;
          end
        end
        StAddrAck: begin
          if (scl_rise && rw_q) begin
            tx_req_d = 1'b1;
          end else if (scl_fall) begin
            if (rw_q) begin
              // Bit 7 goes out on this fall, so one bit is already counted
              sr_d     = {tx_data[6:0], 1'b0};
              sda_oe_d = ~tx_data[7];
              cnt_d    = 4'd1;
              state_d  = StRead;
            end else begin
              sda_oe_d = 1'b0;
              cnt_d    = 4'd0;
              first_d  = 1'b1;
              state_d  = StWrite;
            end
          end
        end
        StWrite: begin
          if (scl_rise) begin
            sr_d  = {sr_q[6:0], sda_s};
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              rx_data_d  = {sr_q[6:0], sda_s};
              rx_valid_d = 1'b1;
              rx_first_d = first_q;
              first_d    = 1'b0;
            end
          end else if (scl_fall && cnt_q == 4'd8) begin
            sda_oe_d = 1'b1;
            cnt_d    = 4'd0;
            state_d  = StWriteAck;
          end
        end
        StWriteAck: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            cnt_d    = 4'd0;
            state_d  = StWrite;
          end
        end
        StRead: begin
          if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              cnt_d    = 4'd0;
              ack_d    = 1'b0;
              state_d  = StMack;
            end else begin
              sda_oe_d = ~sr_q[7];
              sr_d     = {sr_q[6:0], 1'b0};
              cnt_d    = cnt_q + 4'd1;
            end
          end
        end
        StMack: begin
          if (scl_rise) begin
            if (!sda_s) begin
              tx_req_d = 1'b1;
              ack_d    = 1'b1;
            end else begin
              state_d = StIgnore;
            end
          end else if (scl_fall && ack_q) begin
            sr_d     = {tx_data[6:0], 1'b0};
            sda_oe_d = ~tx_data[7];
            cnt_d    = 4'd1;
            state_d  = StRead;
          end
        end
        StIgnore: sda_oe_d = 1'b0;
        default:  state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      scl_q      <= 3'b111;
      sda_q      <= 3'b111;
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      sr_q       <= 8'h00;
      rw_q       <= 1'b0;
      ack_q      <= 1'b0;
      first_q    <= 1'b0;
      sda_oe_q   <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      rx_first_q <= 1'b0;
      tx_req_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      scl_q      <= {scl_q[1:0], scl_in};
      sda_q      <= {sda_q[1:0], sda_in};
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      rw_q       <= rw_d;
      ack_q      <= ack_d;
      first_q    <= first_d;
      sda_oe_q   <= sda_oe_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_first_q <= rx_first_d;
      tx_req_q   <= tx_req_d;
      busy_q     <= busy_d;
    end
  end

  assign sda_oe   = sda_oe_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign rx_first = rx_first_q;
  assign tx_req   = tx_req_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: a bit-banged master drives the bus, a scoreboard holds
// the expected SDA pull per SCL pulse, the expected write bytes and the read
// bytes the core must serve; monitors pop and compare as the DUT responds.
module tb_i2c_slave;
  localparam logic [6:0] Addr = 7'h3e;

  logic       clk = 1'b0;
  logic       res = 1'b0;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       sda_oe, rx_valid, rx_first, tx_req, busy;
  logic [7:0] rx_data;
  logic [7:0] tx_data = 8'h00;
  wire        sda_line = m_sda & ~sda_oe;

  int checks = 0;
  int failures = 0;

  bit         exp_oe[$];    // expected sda_oe per SCL high phase
  logic [8:0] exp_rx[$];    // {first, byte}
  logic [7:0] tx_serve[$];  // bytes the core hands out on tx_req
  logic [7:0] wr_bytes[$];
  logic [7:0] rd_bytes[$];

  i2c_slave #(.SLAVE_ADDR(Addr)) dut (
    .clk      (clk),
    .res      (res),
    .scl_in   (m_scl),
    .sda_in   (sda_line),
    .sda_oe   (sda_oe),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_first (rx_first),
    .tx_req   (tx_req),
    .tx_data  (tx_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // SDA pull monitor: sample mid SCL-high phase
  always @(posedge m_scl) begin
    repeat (2) @(negedge clk);
    if (exp_oe.size() == 0) check("oe_underflow", 32'(exp_oe.size()), 32'd1);
    else check("sda_oe_bit", 32'(sda_oe), 32'(exp_oe.pop_front()));
  end

  // Write-byte monitor
  always @(negedge clk) begin
    if (rx_valid) begin
      if (exp_rx.size() == 0) check("rx_unexpected", 32'(exp_rx.size()), 32'd1);
      else check("rx_byte", 32'({rx_first, rx_data}), 32'(exp_rx.pop_front()));
    end
  end

  // Core model answering read requests
  always @(negedge clk) begin
    if (tx_req) begin
      if (tx_serve.size() == 0) check("tx_req_unexpected", 32'(tx_serve.size()), 32'd1);
      else tx_data = tx_serve.pop_front();
    end
  end

  task automatic wait_q();
    repeat (4) @(negedge clk);
  endtask

  task automatic bus_bit(input logic drive, input bit exp);
    m_sda = drive;
    wait_q();
    exp_oe.push_back(exp);
    m_scl = 1'b1;
    wait_q();
    wait_q();
    m_scl = 1'b0;
    wait_q();
  endtask

  task automatic start_cond();
    m_sda = 1'b1;
    wait_q();
    if (!m_scl) begin
      exp_oe.push_back(1'b0);
      m_scl = 1'b1;
      wait_q();
    end
    m_sda = 1'b0;
    wait_q();
    m_scl = 1'b0;
    wait_q();
  endtask

  task automatic stop_cond();
    m_sda = 1'b0;
    wait_q();
    exp_oe.push_back(1'b0);
    m_scl = 1'b1;
    wait_q();
    m_sda = 1'b1;
    wait_q();
  endtask

  task automatic drain_check();
    repeat (4) @(negedge clk);
    check("rx_missing", 32'(exp_rx.size()), 32'd0);
    check("tx_req_missing", 32'(tx_serve.size()), 32'd0);
    check("oe_leftover", 32'(exp_oe.size()), 32'd0);
  endtask

  // One transaction; write data from wr_bytes, read data from rd_bytes.
  // Reads ACK every byte but the last, which is NACKed.
  task automatic xfer(input logic [7:0] addr, input int n, input bit do_stop);
    bit         hit;
    logic [7:0] d;
    hit = (addr[7:1] == Addr);
    if (hit && addr[0]) for (int k = 0; k < n; k++) tx_serve.push_back(rd_bytes[k]);
    start_cond();
    for (int i = 7; i >= 0; i--) bus_bit(addr[i], 1'b0);
    bus_bit(1'b1, hit);
    check("busy_after_addr", 32'(busy), 32'(hit));
    for (int k = 0; k < n; k++) begin
      if (!addr[0]) begin
        d = wr_bytes[k];
        if (hit) exp_rx.push_back({k == 0, d});
        for (int i = 7; i >= 0; i--) bus_bit(d[i], 1'b0);
        bus_bit(1'b1, hit);
      end else begin
        d = rd_bytes[k];
        for (int i = 7; i >= 0; i--) bus_bit(1'b1, hit & ~d[i]);
        bus_bit(k == n - 1, 1'b0);
      end
    end
    if (do_stop) begin
      stop_cond();
      repeat (4) @(negedge clk);
      check("busy_after_stop", 32'(busy), 32'd0);
    end
    drain_check();
    wr_bytes.delete();
    rd_bytes.delete();
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] a;
    int         n;

    repeat (5) @(negedge clk);
    check("reset_outputs", 32'({sda_oe, rx_valid, rx_first, tx_req, busy, rx_data}), 32'd0);
    res = 1'b1;
    repeat (8) @(negedge clk);

    // Write 0x7c, 0x80, 0x38, STOP
    wr_bytes = '{8'h80, 8'h38};
    xfer(8'h7c, 2, 1'b1);

    // Foreign address: never ACKed
    wr_bytes = '{8'h55, 8'hAA};
    xfer(8'h7e, 2, 1'b1);

    // Read A5 (ACK) then 3C (NACK)
    rd_bytes = '{8'hA5, 8'h3C};
    xfer(8'h7d, 2, 1'b1);
    check("oe_after_nack", 32'(sda_oe), 32'd0);

    // Write one byte, repeated START, read one byte
    wr_bytes = '{8'h80};
    xfer(8'h7c, 1, 1'b0);
    rd_bytes = '{8'h6B};
    xfer(8'h7d, 1, 1'b1);

    // STOP after 4 bits of a data byte
    a = 8'h7c;
    start_cond();
    for (int i = 7; i >= 0; i--) bus_bit(a[i], 1'b0);
    bus_bit(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) bus_bit(1'($urandom_range(0, 1)), 1'b0);
    stop_cond();
    repeat (4) @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_oe", 32'(sda_oe), 32'd0);
    drain_check();
    wr_bytes = '{8'hC3};
    xfer(8'h7c, 1, 1'b1);

    // Reset while the address ACK is being driven
    start_cond();
    for (int i = 7; i >= 0; i--) bus_bit(a[i], 1'b0);
    check("ack_slot_oe", 32'(sda_oe), 32'd1);
    res = 1'b0;
    @(negedge clk);
    check("reset_mid_ack", 32'({sda_oe, rx_valid, rx_first, tx_req, busy, rx_data}), 32'd0);
    repeat (3) @(negedge clk);
    res = 1'b1;
    repeat (4) @(negedge clk);
    wr_bytes = '{8'h12, 8'h34, 8'h56};
    xfer(8'h7c, 3, 1'b1);

    // Randomized traffic
    for (int t = 0; t < 25; t++) begin
      if ($urandom_range(0, 9) < 7) a = {Addr, 1'($urandom_range(0, 1))};
      else a = 8'($urandom);
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) begin
        wr_bytes.push_back(8'($urandom));
        rd_bytes.push_back(8'($urandom));
      end
      xfer(a, n, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_slave.md
# i2c_slave

I2C target (responder) for the far end of the bus driven by the team's I2C master. It oversamples SCL/SDA on the system clock, detects START/STOP, and matches a 7-bit address. On a matching write it delivers each data byte to the core. On a matching read it fetches bytes from the core through a request/data handshake. It drives SDA open-drain only: it pulls SDA low or releases it, and never drives SCL. Used for bench loopback against the master and as the target side in FPGA-to-FPGA links.

## Interface
- `SLAVE_ADDR`, default `7'h3e`: 7-bit target address; write address byte `8'h7c`, read address byte `8'h7d`.
- `clk  input  1`: system clock; must be at least 8x the SCL frequency.
- `res  input  1`: synchronous, active-low reset.
- `scl_in  input  1`: raw SCL pin level, asynchronous.
- `sda_in  input  1`: raw SDA pin level, asynchronous.
- `sda_oe  output  1`: 1 = pull SDA low, 0 = release; the pad is `sda_oe ? 1'b0 : 1'bz`.
- `rx_data  output  8`: last received write byte, MSB first on the wire.
- `rx_valid  output  1`: one-`clk` pulse; `rx_data` is valid in that cycle.
- `rx_first  output  1`: high together with `rx_valid` for the first data byte after the address.
- `tx_req  output  1`: one-`clk` pulse requesting the next read byte.
- `tx_data  input  8`: read byte; sampled at the SCL falling edge that follows `tx_req`.
- `busy  output  1`: high from an address match until the following STOP or START.

## Operation
- Synchronizer: two flops per line, then one history flop. SCL rise/fall and SDA rise/fall are decoded from the synced value and the history flop.
- START: SDA falls while synced SCL = 1. STOP: SDA rises while synced SCL = 1. Both override every state.
  - START from any state: go to ADDR, clear the bit counter, set `sda_oe` = 0. Repeated START is legal.
  - STOP from any state: go to IDLE, set `sda_oe` = 0, `busy` = 0.
- Bits are sampled on SCL rise. `sda_oe` changes only on SCL fall or on reset/STOP/START.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits. On the 8th rise, compare bits [7:1] with `SLAVE_ADDR`.
    - Match: at the next SCL fall go to ADDR_ACK, set `sda_oe` = 1, `busy` = 1.
    - Mismatch: go to IGNORE.
  - ADDR_ACK: on SCL rise, if R/W = 1 pulse `tx_req`. At the SCL fall, release SDA.
    - R/W = 0: go to WRITE.
    - R/W = 1: load `tx_data` into the shift register, drive bit 7, go to READ.
  - WRITE: shift 8 bits. On the 8th rise, update `rx_data` and pulse `rx_valid` (plus `rx_first` for the first byte). At the next fall, set `sda_oe` = 1 and go to WRITE_ACK. Every write byte is ACKed.
  - WRITE_ACK: at the SCL fall, set `sda_oe` = 0 and go to WRITE.
  - READ: on each SCL fall, set `sda_oe` = ~bit and shift the next bit out. At the fall after the 8th bit, set `sda_oe` = 0 and go to MACK.
  - MACK: sample SDA on SCL rise.
    - 0 (ACK): pulse `tx_req`; at the fall, load `tx_data` and go to READ.
    - 1 (NACK): go to IGNORE; no `tx_req`.
  - IGNORE: `sda_oe` = 0 until START or STOP.
- Bit counter: 4 bits, cleared on START and on every ACK-slot exit.

## Timing
- Reset values: `sda_oe` = 0, `rx_data` = 0, `rx_valid` = 0, `rx_first` = 0, `tx_req` = 0, `busy` = 0, state = IDLE. Reset mid-transfer releases SDA in the same cycle it takes effect.
- Edge-detect latency: a pin edge is acted on 3 `clk` after it reaches the synchronizer input.
- `rx_valid` and `tx_req` are single-cycle pulses, 3 `clk` after the relevant SCL rise.
- The core must present `tx_data` before the following SCL fall. With `clk` at 8x SCL that is at least 2 `clk` after `tx_req`.
- SDA-change vs SCL-fall skew is 3–4 `clk`; this meets I2C data hold (tHD;DAT > 0).
- START or STOP in mid-byte aborts the byte: no `rx_valid`, no `tx_req`.

## Test plan
- Write 0x7c, 0x80, 0x38, STOP:
  - ACK (`sda_oe` = 1) in all three ACK slots.
  - `rx_valid` fires twice, with `rx_data` = 0x80 (`rx_first` = 1) then 0x38 (`rx_first` = 0).
  - `busy` falls at STOP.
- Address 0x7e:
  - `sda_oe` stays 0 for the whole transfer; no `rx_valid`; `busy` = 0.
- Read 0x7d with `tx_data` = 0xA5, master ACK, then `tx_data` = 0x3C, master NACK, STOP:
  - SDA carries 10100101 then 00111100.
  - `tx_req` fires exactly twice.
  - `sda_oe` = 0 after the NACK.
- Write 0x7c, 0x80, repeated START, 0x7d, read one byte:
  - One `rx_valid` (0x80).
  - Read phase serves `tx_data` correctly.
- STOP injected after 4 bits of a write data byte:
  - No `rx_valid`; state IDLE; `sda_oe` = 0.
  - Next transfer works.
- Assert `res` = 0 while `sda_oe` = 1 in an ACK slot:
  - `sda_oe` = 0 one `clk` later; all outputs at reset values.
  - A full write after release succeeds.
